// File: rtl/uart_baud_sched_if.sv
// uart_baud_sched_if
//   Bundle between the configuration/autobaud side (master) and the baud
//   scheduler (slave).
//
//   Handshake: host_req/auto_req are levels held, with their divisor
//   stable, until the matching ack pulses for one cycle. The requester
//   drops req right after seeing its ack. A req still high while the
//   scheduler is idle counts as a new request.
//
//   Signals:
//     enable            run the divider (low holds counters at 0)
//     host_req/host_div host divisor update request + value
//     host_ack          one-cycle completion pulse for host
//     auto_req/auto_div autobaud divisor update request + value
//     auto_ack          one-cycle completion pulse for autobaud
//     os_tick/bit_tick  single-cycle oversample / bit ticks
//     cur_div           divisor currently in effect
//     busy              update pending
//     rej               pulses with an ack when a zero divisor is refused
interface uart_baud_sched_if #(
  parameter int DIV_W = 16
);
  logic             enable;
  logic             host_req;
  logic [DIV_W-1:0] host_div;
  logic             host_ack;
  logic             auto_req;
  logic [DIV_W-1:0] auto_div;
  logic             auto_ack;
  logic             os_tick;
  logic             bit_tick;
  logic [DIV_W-1:0] cur_div;
  logic             busy;
  logic             rej;

  modport master (
    output enable, host_req, host_div, auto_req, auto_div,
    input  host_ack, auto_ack, os_tick, bit_tick, cur_div, busy, rej
  );

  modport slave (
    input  enable, host_req, host_div, auto_req, auto_div,
    output host_ack, auto_ack, os_tick, bit_tick, cur_div, busy, rej
  );
endinterface

// File: rtl/uart_baud_sched.sv
// uart_baud_sched
//   Shared UART baud divider. Emits a registered os_tick every cur_div+1
//   enabled cycles and a bit_tick on every OS_RATE-th os_tick. Divisor
//   updates from the host and the autobaud engine are arbitrated
//   round-robin and applied only at a bit boundary (or immediately when
//   the divider is disabled), so no bit in flight changes length.
//
//   Ports:
//     clk          rising-edge clock
//     reset        synchronous, active-high
//     bus          uart_baud_sched_if.slave (see interface file)
//     dbg_state_o  1 while the FSM is in PEND
//
//   Optional feature: define BAUD_SCHED_ZERO_GUARD_EN to refuse a granted
//   divisor of 0 (acked with rej, cur_div kept). Without it rej is 0 and a
//   zero divisor gives a continuous os_tick.
module uart_baud_sched #(
  parameter int DIV_W     = 16,
  parameter int OS_RATE   = 16,
  parameter int RESET_DIV = 325
) (
  input  logic                    clk,
  input  logic                    reset,
  uart_baud_sched_if.slave        bus,
  output logic                    dbg_state_o
);

  localparam int OS_W = $clog2(OS_RATE);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q;
  logic             win_auto_q;
  logic             ptr_auto_q;
  logic             host_ack_q;
  logic             auto_ack_q;
`ifdef BAUD_SCHED_ZERO_GUARD_EN
  logic             rej_q;
`endif

  logic             wrap;
  logic             os_last;
  logic             apply;
  logic             any_req;
  logic             grant_auto;
  logic [DIV_W-1:0] grant_div;

  assign wrap    = bus.enable && (div_cnt_q == cur_div_q);
  assign os_last = (os_cnt_q == OS_W'(OS_RATE - 1));
  // bit_tick_q high means the previous cycle closed a bit, so the counters
  // are at the start of a fresh bit: the only safe point to swap divisors.
  assign apply   = (state_q == S_PEND) && (bit_tick_q || !bus.enable);

  assign any_req    = bus.host_req || bus.auto_req;
  // Auto wins when it is alone or when the pointer favours it.
  assign grant_auto = bus.auto_req && (!bus.host_req || ptr_auto_q);
  assign grant_div  = grant_auto ? bus.auto_div : bus.host_div;

  // Divider next state
  always_comb begin
    div_cnt_d  = div_cnt_q;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    cur_div_d  = cur_div_q;
    if (!bus.enable) begin
      div_cnt_d = '0;
      os_cnt_d  = '0;
    end else begin
      os_tick_d  = wrap;
      bit_tick_d = wrap && os_last;
      if (wrap) begin
        div_cnt_d = '0;
        os_cnt_d  = os_last ? '0 : os_cnt_q + OS_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
    // Restart the bit cleanly on the new divisor; ticks are suppressed so
    // the first os_tick lands new_div+1 cycles after the ack cycle.
    if (apply) begin
      cur_div_d  = pend_div_q;
      div_cnt_d  = '0;
      os_cnt_d   = '0;
      os_tick_d  = 1'b0;
      bit_tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q  <= '0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      cur_div_q  <= DIV_W'(RESET_DIV);
    end else begin
      div_cnt_q  <= div_cnt_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      cur_div_q  <= cur_div_d;
    end
  end

  // Update FSM with registered acks
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pend_div_q <= '0;
      win_auto_q <= 1'b0;
      ptr_auto_q <= 1'b0;
      host_ack_q <= 1'b0;
      auto_ack_q <= 1'b0;
`ifdef BAUD_SCHED_ZERO_GUARD_EN
      rej_q      <= 1'b0;
`endif
    end else begin
      host_ack_q <= 1'b0;
      auto_ack_q <= 1'b0;
`ifdef BAUD_SCHED_ZERO_GUARD_EN
      rej_q      <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            ptr_auto_q <= !grant_auto;
`ifdef BAUD_SCHED_ZERO_GUARD_EN
            if (grant_div == '0) begin
              // Refused straight from IDLE; cur_div is left alone.
              host_ack_q <= !grant_auto;
              auto_ack_q <= grant_auto;
              rej_q      <= 1'b1;
            end else
`endif
            begin
              pend_div_q <= grant_div;
              win_auto_q <= grant_auto;
              state_q    <= S_PEND;
            end
          end
        end
        S_PEND: begin
          // Requests are ignored here; the losing requester simply keeps
          // its req high and is seen again once back in IDLE.
          if (apply) begin
            host_ack_q <= !win_auto_q;
            auto_ack_q <= win_auto_q;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.os_tick  = os_tick_q;
  assign bus.bit_tick = bit_tick_q;
  assign bus.cur_div  = cur_div_q;
  assign bus.host_ack = host_ack_q;
  assign bus.auto_ack = auto_ack_q;
  assign bus.busy     = (state_q == S_PEND);
`ifdef BAUD_SCHED_ZERO_GUARD_EN
  assign bus.rej      = rej_q;
`else
  assign bus.rej      = 1'b0;
`endif
  assign dbg_state_o  = (state_q == S_PEND);

endmodule

// File: tb/tb_uart_baud_sched.sv
// Bench for uart_baud_sched with DIV_W=16, OS_RATE=4, RESET_DIV=4.
// Cycle index cyc is 0 in the first cycle after the last reset edge.
module tb_uart_baud_sched;
  localparam int DIV_W     = 16;
  localparam int OS_RATE   = 4;
  localparam int RESET_DIV = 4;
  localparam int SB_W      = DIV_W + 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic dbg_state;
  int   cyc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  uart_baud_sched_if #(.DIV_W(DIV_W)) bus ();

  uart_baud_sched #(
    .DIV_W(DIV_W),
    .OS_RATE(OS_RATE),
    .RESET_DIV(RESET_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // scoreboard: {is_auto, rej, cur_div after ack}
  logic [SB_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_auto, input logic rej, input logic [DIV_W-1:0] div);
    exp_q.push_back({is_auto, rej, div});
  endtask

  // 0: os_tick, 1: bit_tick, other: either ack
  function automatic logic sig_val(input int sel);
    case (sel)
      0:       return bus.os_tick;
      1:       return bus.bit_tick;
      default: return bus.host_ack | bus.auto_ack;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string tag, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig_val(sel)) begin
        at = cyc;
        break;
      end
    end
    checks++;
    assert (at >= 0) else begin
      errors++;
      $error("FAIL %s: observed no event in %0d cycles, expected event", tag, budget);
    end
  endtask

  // Called at the negedge of an ack cycle: compare against the scoreboard
  // and drop the acked request before the next edge.
  task automatic on_ack(input string tag);
    logic [SB_W-1:0] obs;
    logic [SB_W-1:0] e;
    obs = {bus.auto_ack, bus.rej, bus.cur_div};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed ack %0h expected none", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(obs), 32'(e));
    end
    if (bus.host_ack) bus.host_req = 1'b0;
    if (bus.auto_ack) bus.auto_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    int t0;
    int tb;
    int tb2;
    int ones;
    logic seen;

    reset        = 1'b1;
    bus.enable   = 1'b1;
    bus.host_req = 1'b0;
    bus.host_div = '0;
    bus.auto_req = 1'b0;
    bus.auto_div = '0;

    // reset values
    @(negedge clk);
    chk("rst_cur_div", bus.cur_div, RESET_DIV);
    chk("rst_os_tick", bus.os_tick, 0);
    chk("rst_bit_tick", bus.bit_tick, 0);
    chk("rst_acks", {bus.host_ack, bus.auto_ack}, 0);
    chk("rst_rej", bus.rej, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_state", dbg_state, 0);
    next_cycle();
    reset = 1'b0;

    // free-running divider at RESET_DIV
    wait_for(0, 20, "os_first", t);
    chk("os_first_cyc", t, 5);
    wait_for(0, 20, "os_second", t);
    chk("os_period", t, 10);
    chk("cur_div_init", bus.cur_div, 4);
    wait_for(1, 40, "bit_first", t);
    chk("bit_first_cyc", t, 20);
    chk("bit_os_align", bus.os_tick, 1);
    wait_for(1, 40, "bit_second", t);
    chk("bit_period", t, 40);

    // host request of 2 mid-bit
    repeat (3) next_cycle();
    bus.host_div = 16'd2;
    bus.host_req = 1'b1;
    push_exp(1'b0, 1'b0, 16'd2);
    @(negedge clk);
    chk("busy_before", bus.busy, 0);
    @(negedge clk);
    chk("busy_rise", bus.busy, 1);
    wait_for(1, 40, "bit_pend", tb);
    chk("bit_pend_cyc", tb, 60);
    wait_for(2, 10, "host_ack", t);
    chk("host_ack_lat", t, tb + 1);
    on_ack("host_div2");
    chk("busy_after_ack", bus.busy, 0);
    @(negedge clk);
    chk("host_ack_pulse", bus.host_ack, 0);
    wait_for(0, 10, "os_div2_a", t);
    chk("os_div2_first", t, tb + 1 + 3);
    wait_for(0, 10, "os_div2_b", t);
    chk("os_div2_p1", t, tb + 1 + 6);
    wait_for(0, 10, "os_div2_c", t);
    chk("os_div2_p2", t, tb + 1 + 9);

    // simultaneous requests straight out of reset
    next_cycle();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset        = 1'b0;
    bus.host_div = 16'd6;
    bus.auto_div = 16'd9;
    bus.host_req = 1'b1;
    bus.auto_req = 1'b1;
    push_exp(1'b0, 1'b0, 16'd6);
    push_exp(1'b1, 1'b0, 16'd9);
    @(negedge clk);
    chk("dual_idle", dbg_state, 0);
    @(negedge clk);
    chk("dual_pend", dbg_state, 1);
    wait_for(2, 60, "dual_first", t);
    chk("dual_first_cyc", t, 21);
    on_ack("dual_host");
    wait_for(2, 60, "dual_second", t);
    chk("dual_second_cyc", t, 50);
    on_ack("dual_auto");

    // update while disabled
    next_cycle();
    bus.enable = 1'b0;
    next_cycle();
    next_cycle();
    bus.auto_div = 16'd7;
    bus.auto_req = 1'b1;
    t0 = cyc;
    push_exp(1'b1, 1'b0, 16'd7);
    wait_for(2, 10, "auto_dis", t);
    chk("auto_dis_lat", t, t0 + 2);
    chk("dis_no_os", bus.os_tick, 0);
    chk("dis_no_bit", bus.bit_tick, 0);
    on_ack("auto_div7");
    next_cycle();
    bus.enable = 1'b1;
    t0 = cyc;
    wait_for(0, 20, "os_reenable", t);
    chk("os_reenable_lat", t, t0 + 8);

    // reset while an update is pending
    next_cycle();
    bus.host_div = 16'd3;
    bus.host_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pend_busy", bus.busy, 1);
    next_cycle();
    next_cycle();
    reset        = 1'b1;
    bus.host_req = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("rst_pend_busy", bus.busy, 0);
    chk("rst_pend_div", bus.cur_div, 4);
    chk("rst_pend_ack", bus.host_ack, 0);
    next_cycle();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | bus.host_ack | bus.auto_ack;
    end
    chk("rst_pend_no_ack", seen, 0);

    // divisor 0 from host
    next_cycle();
    bus.host_div = 16'd0;
    bus.host_req = 1'b1;
    t0 = cyc;
`ifdef BAUD_SCHED_ZERO_GUARD_EN
    push_exp(1'b0, 1'b1, 16'd4);
    wait_for(2, 5, "zero_ack", t);
    chk("zero_ack_lat", t, t0 + 1);
    chk("zero_rej", bus.rej, 1);
    chk("zero_busy", bus.busy, 0);
    on_ack("zero_guard");
`else
    push_exp(1'b0, 1'b0, 16'd0);
    wait_for(2, 40, "zero_ack", t);
    chk("zero_ack_cyc", t, 21);
    on_ack("zero_apply");
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.os_tick) ones++;
    end
    chk("zero_os_cont", ones, 8);
    wait_for(1, 10, "zero_bit_a", tb);
    wait_for(1, 10, "zero_bit_b", tb2);
    chk("zero_bit_period", tb2 - tb, OS_RATE);
`endif

    // pointer moved to auto after the host grant
    next_cycle();
    bus.host_div = 16'd5;
    bus.auto_div = 16'd3;
    bus.host_req = 1'b1;
    bus.auto_req = 1'b1;
    push_exp(1'b1, 1'b0, 16'd3);
    push_exp(1'b0, 1'b0, 16'd5);
    wait_for(2, 200, "rr_first", t);
    on_ack("rr_first");
    wait_for(2, 200, "rr_second", t);
    on_ack("rr_second");

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_baud_sched.md
# uart_baud_sched

Baud-rate scheduler for the UART. Runs the shared divider, emits single-cycle oversample and bit ticks, and arbitrates divisor updates from two requesters (host register interface and autobaud engine). Each update is applied only at a bit boundary so no in-flight bit is stretched or truncated. Sits between the configuration logic and the TX/RX engines, which consume `os_tick` and `bit_tick`.

## Interface
- `DIV_W`, 16, divisor width.
- `OS_RATE`, 16, oversample ticks per bit; must be ≥2.
- `RESET_DIV`, 325, divisor loaded at reset.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: run the divider; low holds the counters at 0.
- `host_req` in 1: host update request; level, held until `host_ack`.
- `host_div` in DIV_W: requested divisor; stable while `host_req` is high.
- `host_ack` out 1: one-cycle pulse; the request has completed.
- `auto_req` in 1: autobaud update request; same rules as `host_req`.
- `auto_div` in DIV_W: autobaud divisor.
- `auto_ack` out 1: one-cycle completion pulse.
- `os_tick` out 1: one-cycle pulse every `cur_div+1` cycles while enabled.
- `bit_tick` out 1: coincides with every `OS_RATE`-th `os_tick`.
- `cur_div` out DIV_W: divisor currently in effect.
- `busy` out 1: high while an update is pending (state PEND).
- `rej` out 1: pulses with an ack when the update is rejected (see Configuration).

## Operation
- Divider:
  - `div_cnt` counts 0..`cur_div`, then wraps to 0.
  - The wrap cycle is the cycle in which `div_cnt==cur_div` and `enable=1`.
  - `os_tick` is registered: it goes high in the cycle after the wrap cycle.
  - `os_cnt` counts wraps modulo `OS_RATE`.
  - `bit_tick` is registered: high after a wrap cycle in which `os_cnt==OS_RATE-1`.
- With `enable=0`: `div_cnt`, `os_cnt`, `os_tick` and `bit_tick` are all held at 0.
- State machine, states IDLE and PEND:
  - IDLE, no request pending: stay in IDLE.
  - IDLE, one or more requests: the arbiter selects a winner, latches the winner's divisor into `pend_div` and the winner's ID, and moves to PEND.
  - PEND exits when `bit_tick=1` or `enable=0` in the current cycle. On the next edge:
    - `cur_div <= pend_div`;
    - `div_cnt` and `os_cnt` are cleared;
    - the winner's ack goes high for one cycle;
    - the FSM returns to IDLE.
  - PEND ignores all requests.
- Arbitration is round-robin:
  - The pointer favours host after reset.
  - After each grant, the pointer moves to the other requester.
  - A lone requester always wins.
- Requester rule: drop `req` in the cycle immediately after its ack. A `req` still high in IDLE is treated as a new request.
- `busy` = (state==PEND).

## Timing
- Reset values:
  - `cur_div=RESET_DIV`;
  - `os_tick=0`, `bit_tick=0`, `host_ack=0`, `auto_ack=0`, `rej=0`, `busy=0`;
  - state IDLE, pointer=host.
- Reset during PEND discards the pending update; no ack is issued.
- Request to `busy`:
  - `req` is sampled at edge N; `busy=1` from N.
  - Ack arrives at the edge after the next `bit_tick` (or immediately after a cycle with `enable=0`).
  - Worst case while enabled: (`cur_div`+1)·`OS_RATE`+2 cycles.
- After an apply, the first `os_tick` occurs `new_div+1` cycles after the ack cycle.
- `cur_div=0`: `os_tick` stays high continuously; `bit_tick` pulses every `OS_RATE` cycles.
- `enable` deasserted mid-bit: the counters clear on the next edge, and no partial tick is emitted.

## Configuration
- Macro `BAUD_SCHED_ZERO_GUARD_EN`.
- Defined:
  - A granted divisor of 0 is not latched. It is acked and `rej` pulses in the cycle after the sample, straight from IDLE without entering PEND.
  - `cur_div` is unchanged.
  - The pointer still advances.
- Undefined:
  - `rej` is tied to 0.
  - A divisor of 0 is applied like any other value, giving a continuous `os_tick`.

## Test plan
- Reset with `RESET_DIV=4`, `OS_RATE=4`, `enable=1`:
  - `os_tick` pulses every 5 cycles.
  - `bit_tick` pulses every 20 cycles, aligned with `os_tick`.
  - `cur_div=4`.
- Host request of divisor 2 mid-bit:
  - `busy` rises the next cycle.
  - `host_ack` arrives exactly one cycle after the next `bit_tick`, with `cur_div=2`.
  - `os_tick` then pulses every 3 cycles.
- `host_req` and `auto_req` raised together from reset (divisors 6 and 9):
  - Host is acked first.
  - Auto is granted at the next IDLE and acked one bit later.
  - Final `cur_div=9`.
- `enable=0` with auto request of divisor 7:
  - `auto_ack` arrives 2 cycles after `req` is sampled.
  - `cur_div=7`; no ticks emitted.
  - Re-enable: first `os_tick` 8 cycles later.
- Assert `reset` while `busy=1`:
  - No ack is issued.
  - `cur_div` returns to 4; `busy=0`.
- Divisor 0 from host:
  - With the macro: `host_ack` and `rej` both pulse 1 cycle after the sample; `cur_div` is unchanged.
  - Without the macro: the update is applied at the boundary and `os_tick` stays high continuously.
